// File: rtl/toy_pkg.sv
// toy_pkg: shared definitions for the toy CPU ALU sequencer.
//   - datapath / register-file geometry
//   - opcode encodings
//   - sequencer state enum
//   - instruction field positions and slice helpers
package toy_pkg;

  localparam int TOY_DATA_W   = 16;
  localparam int TOY_RF_DEPTH = 8;
  localparam int RF_AW        = 3;
  localparam int OP_W         = 3;
  localparam int IMM_W        = 10;

  // Opcodes
  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_LDI = 3'b010;
  localparam logic [OP_W-1:0] OP_ILL = 3'b011;
  localparam logic [OP_W-1:0] OP_SHL = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR = 3'b101;
  localparam logic [OP_W-1:0] OP_OR  = 3'b110;
  localparam logic [OP_W-1:0] OP_AND = 3'b111;

  // Instruction field positions: [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt, [9:0] imm10
  localparam int OP_LSB = 13;
  localparam int RD_LSB = 10;
  localparam int RS_LSB = 7;
  localparam int RT_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  function automatic logic [OP_W-1:0] instr_op(input logic [TOY_DATA_W-1:0] ins);
    return ins[OP_LSB +: OP_W];
  endfunction

  function automatic logic [RF_AW-1:0] instr_rd(input logic [TOY_DATA_W-1:0] ins);
    return ins[RD_LSB +: RF_AW];
  endfunction

  function automatic logic [RF_AW-1:0] instr_rs(input logic [TOY_DATA_W-1:0] ins);
    return ins[RS_LSB +: RF_AW];
  endfunction

  function automatic logic [RF_AW-1:0] instr_rt(input logic [TOY_DATA_W-1:0] ins);
    return ins[RT_LSB +: RF_AW];
  endfunction

  // LDI immediate, zero-extended to the datapath width
  function automatic logic [TOY_DATA_W-1:0] ldi_value(input logic [TOY_DATA_W-1:0] ins);
    return {{(TOY_DATA_W-IMM_W){1'b0}}, ins[IMM_W-1:0]};
  endfunction

endpackage

// File: rtl/toy_alu_sequencer_if.sv
// toy_alu_sequencer_if: fetch-side handshake and ALU port set of the sequencer.
//   instr_valid/instr/instr_ready : instruction handshake from fetch
//   alu_op/alu_a/alu_src          : operation and operands to the external ALU
//   alu_rd/alu_c                  : result and carry back from the ALU
// Modports: slave = the sequencer, master = fetch stage + ALU environment.
interface toy_alu_sequencer_if;

  logic                                  instr_valid;
  logic [toy_pkg::TOY_DATA_W-1:0]        instr;
  logic                                  instr_ready;
  logic [toy_pkg::OP_W-1:0]              alu_op;
  logic [toy_pkg::TOY_DATA_W-1:0]        alu_a;
  logic [toy_pkg::TOY_DATA_W-1:0]        alu_src;
  logic [toy_pkg::TOY_DATA_W-1:0]        alu_rd;
  logic                                  alu_c;

  modport slave (
    input  instr_valid, instr, alu_rd, alu_c,
    output instr_ready, alu_op, alu_a, alu_src
  );

  modport master (
    output instr_valid, instr, alu_rd, alu_c,
    input  instr_ready, alu_op, alu_a, alu_src
  );

endinterface

// File: rtl/toy_regfile.sv
// toy_regfile: 8x16 register file.
//   clk, rst_n          : clock, asynchronous active-low clear of all registers
//   ra_addr / ra_data   : async read port A
//   rb_addr / rb_data   : async read port B
//   dbg_addr / dbg_data : async debug read port
//   we, waddr, wdata    : synchronous write port
// R0 is never written, so it always reads 0.
module toy_regfile
  import toy_pkg::*;
#(
  parameter int DATA_W   = TOY_DATA_W,
  parameter int RF_DEPTH = TOY_RF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RF_AW-1:0]  ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [RF_AW-1:0]  rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [RF_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [RF_AW-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [RF_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/toy_alu_sequencer.sv
// toy_alu_sequencer: multi-cycle issue/writeback controller for the toy CPU ALU.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : instruction handshake in, ALU operands out, ALU result/carry in
//   done                : 1-cycle pulse when a writeback (or LDI) completes
//   illegal             : 1-cycle pulse when opcode 011 is rejected
//   flag_z, flag_c      : zero / carry flags from the last ALU writeback
//   dbg_addr, dbg_data  : combinational register-file debug read
// Build option: SHL_CARRY_EN - when defined, SHL puts the shifted-out bit alu_a[15]
// into the carry; otherwise SHL clears the carry.
module toy_alu_sequencer
  import toy_pkg::*;
#(
  parameter int DATA_W   = TOY_DATA_W,
  parameter int RF_DEPTH = TOY_RF_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  toy_alu_sequencer_if.slave  bus,
  output logic                done,
  output logic                illegal,
  output logic                flag_z,
  output logic                flag_c,
  input  logic [RF_AW-1:0]    dbg_addr,
  output logic [DATA_W-1:0]   dbg_data
);

  state_t            state_reg;
  logic [DATA_W-1:0] instr_reg;
  logic [DATA_W-1:0] res_reg;
  logic              carry_reg;
  logic [OP_W-1:0]   alu_op_reg;
  logic [DATA_W-1:0] alu_a_reg;
  logic [DATA_W-1:0] alu_src_reg;
  logic              done_reg;
  logic              illegal_reg;
  logic              flag_z_reg;
  logic              flag_c_reg;

  logic [OP_W-1:0]   op;
  logic [RF_AW-1:0]  rd;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              exec_carry;

  assign op = instr_op(instr_reg);
  assign rd = instr_rd(instr_reg);

  // The only two writers are LDI (straight out of DECODE) and the WB state.
  assign wr_en   = (state_reg == ST_WB) || ((state_reg == ST_DECODE) && (op == OP_LDI));
  assign wr_data = (state_reg == ST_WB) ? res_reg : ldi_value(instr_reg);

  toy_regfile #(
    .DATA_W   (DATA_W),
    .RF_DEPTH (RF_DEPTH)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (instr_rs(instr_reg)),
    .ra_data  (rs_data),
    .rb_addr  (instr_rt(instr_reg)),
    .rb_data  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wr_en),
    .waddr    (rd),
    .wdata    (wr_data)
  );

  // The external ALU drives alu_c for every op; only ADD's carry is trusted.
  always_comb begin
    exec_carry = 1'b0;
    if (alu_op_reg == OP_ADD) begin
      exec_carry = bus.alu_c;
    end
`ifdef SHL_CARRY_EN
    else if (alu_op_reg == OP_SHL) begin
      exec_carry = alu_a_reg[DATA_W-1];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      instr_reg   <= '0;
      res_reg     <= '0;
      carry_reg   <= 1'b0;
      alu_op_reg  <= '0;
      alu_a_reg   <= '0;
      alu_src_reg <= '0;
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      flag_z_reg  <= 1'b0;
      flag_c_reg  <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            instr_reg <= bus.instr;
            state_reg <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (op == OP_LDI) begin
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end else if (op == OP_ILL) begin
            illegal_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end else begin
            alu_op_reg  <= op;
            alu_a_reg   <= rs_data;
            alu_src_reg <= rt_data;
            state_reg   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_reg   <= bus.alu_rd;
          carry_reg <= exec_carry;
          state_reg <= ST_WB;
        end
        ST_WB: begin
          flag_c_reg <= carry_reg;
          flag_z_reg <= (res_reg == '0) && !carry_reg;
          done_reg   <= 1'b1;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (state_reg == ST_IDLE);
  assign bus.alu_op      = alu_op_reg;
  assign bus.alu_a       = alu_a_reg;
  assign bus.alu_src     = alu_src_reg;
  assign done            = done_reg;
  assign illegal         = illegal_reg;
  assign flag_z          = flag_z_reg;
  assign flag_c          = flag_c_reg;

endmodule
